// File: rtl/sum_ch_acc.sv
// Channel combiner: sums NUM_CH time-multiplexed scaled I/Q samples per frame
// and emits one saturated I/Q sum per completed frame.
module sum_ch_acc #(
  parameter int NUM_CH = 4,
  parameter int DW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din_i,
  input  logic [DW-1:0] din_q,
  input  logic          din_valid,
  input  logic          din_first,
  output logic [DW-1:0] sum_i,
  output logic [DW-1:0] sum_q,
  output logic          sum_valid,
  output logic          sat_flag,
  output logic          frame_err
);

  // state  | meaning
  // S_IDLE | no frame open; waiting for a channel-0 sample
  // S_ACC  | frame open; ch_cnt channels already accumulated

  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = DW + $clog2(NUM_CH);

  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [CW-1:0]           LAST = CW'(NUM_CH - 1);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [CW-1:0]           ch_cnt_q, ch_cnt_d;
  logic [DW-1:0]           sum_i_q, sum_i_d, sum_q_q, sum_q_d;
  logic                    sum_valid_q, sum_valid_d;
  logic                    sat_flag_q, sat_flag_d;
  logic                    frame_err_q, frame_err_d;

  logic signed [ACC_W-1:0] ext_i, ext_q, tot_i, tot_q;
  logic                    clip_i, clip_q;
  logic [DW-1:0]           sat_i, sat_q;

  // Frame total including the current beat, clipped to DW only at the output.
  always_comb begin
    ext_i  = {{(ACC_W-DW){din_i[DW-1]}}, din_i};
    ext_q  = {{(ACC_W-DW){din_q[DW-1]}}, din_q};
    tot_i  = acc_i_q + ext_i;
    tot_q  = acc_q_q + ext_q;
    clip_i = (tot_i > SMAX) || (tot_i < SMIN);
    clip_q = (tot_q > SMAX) || (tot_q < SMIN);
    sat_i  = (tot_i > SMAX) ? SMAX[DW-1:0] : (tot_i < SMIN) ? SMIN[DW-1:0] : tot_i[DW-1:0];
    sat_q  = (tot_q > SMAX) ? SMAX[DW-1:0] : (tot_q < SMIN) ? SMIN[DW-1:0] : tot_q[DW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    ch_cnt_d    = ch_cnt_q;
    sum_i_d     = sum_i_q;
    sum_q_d     = sum_q_q;
    sum_valid_d = 1'b0;
    sat_flag_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (din_valid && din_first) begin
          acc_i_d  = ext_i;
          acc_q_d  = ext_q;
          ch_cnt_d = CW'(1);
          state_d  = S_ACC;
        end
      end
      S_ACC: begin
        if (din_valid) begin
          if (din_first) begin
            frame_err_d = 1'b1;
            acc_i_d     = ext_i;
            acc_q_d     = ext_q;
            ch_cnt_d    = CW'(1);
          end else if (ch_cnt_q == LAST) begin
            sum_i_d     = sat_i;
            sum_q_d     = sat_q;
            sum_valid_d = 1'b1;
            sat_flag_d  = clip_i | clip_q;
            ch_cnt_d    = '0;
            state_d     = S_IDLE;
          end else begin
            acc_i_d  = tot_i;
            acc_q_d  = tot_q;
            ch_cnt_d = ch_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      ch_cnt_q    <= '0;
      sum_i_q     <= '0;
      sum_q_q     <= '0;
      sum_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      ch_cnt_q    <= ch_cnt_d;
      sum_i_q     <= sum_i_d;
      sum_q_q     <= sum_q_d;
      sum_valid_q <= sum_valid_d;
      sat_flag_q  <= sat_flag_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sum_i     = sum_i_q;
  assign sum_q     = sum_q_q;
  assign sum_valid = sum_valid_q;
  assign sat_flag  = sat_flag_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sum_ch_acc.sv
// Bench for sum_ch_acc: scenario tasks checked against a queue-based frame model.
module tb_sum_ch_acc;
  localparam int NUM_CH = 4;
  localparam int DW     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din_i = '0, din_q = '0;
  logic          din_valid = 1'b0, din_first = 1'b0;
  logic [DW-1:0] sum_i, sum_q;
  logic          sum_valid, sat_flag, frame_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: samples of the open frame, expected outputs
  int         fr_i[$];
  int         fr_q[$];
  bit         in_frame = 0;
  bit         m_valid = 0, m_sat = 0, m_err = 0;
  logic [15:0] m_sum_i = '0, m_sum_q = '0;
  logic [34:0] obs, exp_v;

  sum_ch_acc #(.NUM_CH(NUM_CH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .din_i(din_i), .din_q(din_q),
    .din_valid(din_valid), .din_first(din_first),
    .sum_i(sum_i), .sum_q(sum_q), .sum_valid(sum_valid),
    .sat_flag(sat_flag), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return int'(t);
  endfunction

  function automatic int clamp(input int s, output bit c);
    c = 0;
    if (s > 32767) begin s = 32767; c = 1; end
    if (s < -32768) begin s = -32768; c = 1; end
    return s;
  endfunction

  // Applies one cycle of input, then advances the model to what the DUT should show.
  task automatic beat(input bit r, input bit v, input bit f, input int i, input int q);
    int si, sq, vi, vq;
    bit ci, cq;
    @(negedge clk);
    rst = r; din_valid = v; din_first = f; din_i = i[15:0]; din_q = q[15:0];
    @(posedge clk);
    #1;
    m_valid = 0; m_sat = 0; m_err = 0;
    if (r) begin
      fr_i.delete(); fr_q.delete(); in_frame = 0;
      m_sum_i = '0; m_sum_q = '0;
    end else if (v && f) begin
      if (in_frame) m_err = 1;
      fr_i.delete(); fr_q.delete();
      fr_i.push_back(i); fr_q.push_back(q);
      in_frame = 1;
    end else if (v && in_frame) begin
      fr_i.push_back(i); fr_q.push_back(q);
      if (fr_i.size() == NUM_CH) begin
        si = 0; sq = 0;
        foreach (fr_i[k]) begin si += fr_i[k]; sq += fr_q[k]; end
        vi = clamp(si, ci);
        vq = clamp(sq, cq);
        m_sum_i = vi[15:0]; m_sum_q = vq[15:0];
        m_valid = 1; m_sat = ci | cq;
        fr_i.delete(); fr_q.delete(); in_frame = 0;
      end
    end
    obs   = {sum_valid, sat_flag, frame_err, sum_i, sum_q};
    exp_v = {m_valid, m_sat, m_err, m_sum_i, m_sum_q};
  endtask

  task automatic test_reset();
    beat(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      beat(1, 1'($urandom), 1'($urandom), rnd16(), rnd16());
      n_vec++;
      if (obs !== 35'd0) begin
        n_err++;
        $display("FAIL reset cyc %0d: got v/s/e/i/q=%h want 0", k, obs);
      end
    end
  endtask

  task automatic test_back_to_back();
    int vi[4] = '{100, 200, 300, 400};
    int vq[4] = '{-1, -2, -3, -4};
    for (int fr = 0; fr < 3; fr++)
      for (int k = 0; k < 4; k++) begin
        beat(0, 1, k == 0, vi[k], vq[k]);
        n_vec++;
        if (obs !== exp_v || (k == 3 && (sum_valid !== 1'b1 || $signed(sum_i) != 1000
            || $signed(sum_q) != -10 || sat_flag !== 1'b0))) begin
          n_err++;
          $display("FAIL back_to_back fr %0d beat %0d: got %h want %h", fr, k, obs, exp_v);
        end
      end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) begin
      beat(0, 1, k == 0, 20000, -20000);
      n_vec++;
      if (obs !== exp_v || (k == 3 && (sum_i !== 16'h7fff || sum_q !== 16'h8000
          || sat_flag !== 1'b1))) begin
        n_err++;
        $display("FAIL saturation beat %0d: got %h want %h", k, obs, exp_v);
      end
    end
    for (int k = 0; k < 4; k++) begin
      beat(0, 1, k == 0, 0, 0);
      n_vec++;
      if (obs !== exp_v || (k == 3 && (sum_i !== 16'd0 || sum_q !== 16'd0
          || sat_flag !== 1'b0 || sum_valid !== 1'b1))) begin
        n_err++;
        $display("FAIL zero_after_sat beat %0d: got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_gaps();
    int vi[4] = '{100, 200, 300, 400};
    int vq[4] = '{-1, -2, -3, -4};
    for (int fr = 0; fr < 3; fr++)
      for (int k = 0; k < 4; k++) begin
        beat(0, 1, k == 0, vi[k], vq[k]);
        n_vec++;
        if (obs !== exp_v || (k == 3 && (sum_valid !== 1'b1 || $signed(sum_i) != 1000
            || $signed(sum_q) != -10))) begin
          n_err++;
          $display("FAIL gaps fr %0d beat %0d: got %h want %h", fr, k, obs, exp_v);
        end
        if (k < 3) begin
          for (int g = 0; g < $urandom_range(0, 3); g++) begin
            beat(0, 0, 1'($urandom), rnd16(), rnd16());
            n_vec++;
            if (obs !== exp_v || sum_valid !== 1'b0) begin
              n_err++;
              $display("FAIL gaps idle fr %0d: got %h want %h", fr, obs, exp_v);
            end
          end
        end
      end
  endtask

  task automatic test_restart();
    int fi[6], fq[6];
    bit ff[6] = '{1, 0, 1, 0, 0, 0};
    int ei, eq;
    ei = 0; eq = 0;
    for (int k = 0; k < 6; k++) begin
      fi[k] = rnd16() / 4; fq[k] = rnd16() / 4;
      if (k >= 2) begin ei += fi[k]; eq += fq[k]; end
    end
    for (int k = 0; k < 6; k++) begin
      beat(0, 1, ff[k], fi[k], fq[k]);
      n_vec++;
      if (obs !== exp_v || frame_err !== (k == 2) || sum_valid !== (k == 5)
          || (k == 5 && ($signed(sum_i) != ei || $signed(sum_q) != eq))) begin
        n_err++;
        $display("FAIL restart beat %0d: got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_idle_rst();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      beat(0, 1, 0, rnd16(), rnd16());
      n_vec++;
      if (obs !== exp_v || sum_valid !== 1'b0 || frame_err !== 1'b0) begin
        n_err++;
        $display("FAIL idle_ignore beat %0d: got %h want %h", k, obs, exp_v);
      end
    end
    beat(0, 1, 1, 5, 6);
    beat(0, 1, 0, 7, 8);
    beat(1, 1, 0, 9, 9);
    n_vec++;
    if (obs !== 35'd0) begin
      n_err++;
      $display("FAIL mid_frame_rst: got %h want 0", obs);
    end
    for (int k = 0; k < 6; k++) begin
      beat(0, k < 4, k == 0, 1000 * (k + 1), -7 * (k + 1));
      if (sum_valid === 1'b1) pulses++;
      n_vec++;
      if (obs !== exp_v || (k == 3 && ($signed(sum_i) != 10000 || $signed(sum_q) != -70))) begin
        n_err++;
        $display("FAIL after_rst beat %0d: got %h want %h", k, obs, exp_v);
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL after_rst pulse count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_random();
    bit v, f;
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 5) == 0) || (!in_frame && $urandom_range(0, 1) == 1);
      beat(0, v, f, rnd16(), rnd16());
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL random beat %0d: got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_saturation();
    test_gaps();
    test_restart();
    test_idle_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
